// File: rtl/spi_pkg.sv
// Shared definitions for the SPI word capture block: default sizes, FSM
// encoding and the idle line levels the input synchronizers reset to.
package spi_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int SYNC_DEF  = 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RECV = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RECV = ST_RECV,
        DONE = ST_DONE
    } state_e;

    localparam logic SCLK_RST_LVL = 1'b0;
    localparam logic CS_RST_LVL   = 1'b1;
    localparam logic MOSI_RST_LVL = 1'b0;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer for one asynchronous pad, plus registered rise/fall
// strobes. The level output is delayed to line up with the strobes.
module spi_sync_edge
    import spi_pkg::*;
#(
    parameter int   SYNC_STAGES = SYNC_DEF,
    parameter logic RST_LVL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], din};
        level_d = sync_q[SYNC_STAGES-1];
        rise_d  = sync_q[SYNC_STAGES-1] & ~level_q;
        fall_d  = ~sync_q[SYNC_STAGES-1] & level_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q  <= {SYNC_STAGES{RST_LVL}};
            level_q <= RST_LVL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/spi_word_capture.sv
// SPI mode-0 slave receiver: captures one WIDTH-bit word per chip-select frame,
// echoes the previously held word on miso and flags frames cut short.
module spi_word_capture
    import spi_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEF,
    parameter int SYNC_STAGES = SYNC_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclk,
    input  logic             cs_n,
    input  logic             mosi,
    output logic             miso,
    output logic [WIDTH-1:0] value,
    output logic             word_valid,
    output logic             frame_err
);

    localparam int              CW        = $clog2(WIDTH + 1);
    localparam int              FW        = $clog2(SYNC_STAGES + 3);
    localparam logic [CW-1:0]   LAST_BIT  = CW'(WIDTH - 1);
    localparam logic [FW-1:0]   FLUSH_END = FW'(SYNC_STAGES + 2);

    logic sclk_lvl_unused, rise_sclk, fall_sclk;
    logic cs_lvl, rise_cs, fall_cs;
    logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_LVL(SCLK_RST_LVL)) u_sclk (
        .clk(clk), .rst(rst), .din(sclk),
        .level(sclk_lvl_unused), .rise(rise_sclk), .fall(fall_sclk)
    );
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_LVL(CS_RST_LVL)) u_cs (
        .clk(clk), .rst(rst), .din(cs_n),
        .level(cs_lvl), .rise(rise_cs), .fall(fall_cs)
    );
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_LVL(MOSI_RST_LVL)) u_mosi (
        .clk(clk), .rst(rst), .din(mosi),
        .level(mosi_lvl), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    state_e           state_q, state_d;
    logic [WIDTH-2:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] tx_q, tx_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic             miso_q, miso_d;
    logic             word_valid_q, word_valid_d;
    logic             frame_err_q, frame_err_d;
    logic [FW-1:0]    flush_q, flush_d;
    logic             armed_q, armed_d;

    // A frame may only start after cs_n has been seen high once the synchronizer
    // has flushed its reset levels, so a cs_n held low across reset is ignored.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        tx_d         = tx_q;
        value_d      = value_q;
        miso_d       = miso_q;
        word_valid_d = 1'b0;
        frame_err_d  = frame_err_q;
        flush_d      = (flush_q == FLUSH_END) ? flush_q : flush_q + 1'b1;
        armed_d      = armed_q | ((flush_q == FLUSH_END) & cs_lvl);

        unique case (state_q)
            IDLE: begin
                if (fall_cs && armed_q) begin
                    tx_d    = value_q;
                    miso_d  = value_q[WIDTH-1];
                    cnt_d   = '0;
                    state_d = RECV;
                end
            end
            RECV: begin
                // cs_n rising ends the frame even if an sclk rise lands in the same cycle.
                if (rise_cs) begin
                    if (cnt_q != '0) frame_err_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    if (rise_sclk) begin
                        shift_d = {shift_q[WIDTH-3:0], mosi_lvl};
                        cnt_d   = cnt_q + 1'b1;
                        if (cnt_q == LAST_BIT) begin
                            value_d      = {shift_q, mosi_lvl};
                            word_valid_d = 1'b1;
                            frame_err_d  = 1'b0;
                            state_d      = DONE;
                        end
                    end
                    if (fall_sclk) begin
                        tx_d   = tx_q << 1;
                        miso_d = tx_q[WIDTH-2];
                    end
                end
            end
            DONE: begin
                if (rise_cs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            cnt_q        <= '0;
            tx_q         <= '0;
            value_q      <= '0;
            miso_q       <= 1'b0;
            word_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            flush_q      <= '0;
            armed_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            tx_q         <= tx_d;
            value_q      <= value_d;
            miso_q       <= miso_d;
            word_valid_q <= word_valid_d;
            frame_err_q  <= frame_err_d;
            flush_q      <= flush_d;
            armed_q      <= armed_d;
        end
    end

    assign miso       = miso_q;
    assign value      = value_q;
    assign word_valid = word_valid_q;
    assign frame_err  = frame_err_q;

endmodule

// File: doc/spi_word_capture.md
Name: spi_word_capture

Overview:
- SPI mode-0 slave receiver, oversampled by the system clock. Assembles one WIDTH-bit word per chip-select frame and holds it in a register.
- The held word drives the 16-bit value input of the LED display stage directly downstream.
- Echoes the previously captured word on miso, so the master can read back what the LEDs show.
- Reports frames aborted mid-word.

Parameters:
- WIDTH, 16, bits per word; equals the downstream display width.
- SYNC_STAGES, 2, flip-flop depth of the input synchronizers on sclk, mosi and cs_n (minimum 2).

Ports:
- clk  in  1  system clock; must be at least 8x the sclk frequency.
- rst  in  1  asynchronous, active-low reset; asserts asynchronously, releases on clk.
- sclk  in  1  SPI clock from the master, asynchronous to clk.
- cs_n  in  1  SPI chip select, active low, asynchronous.
- mosi  in  1  SPI data in, MSB first.
- miso  out  1  SPI data out, MSB first.
- value  out  WIDTH  last complete word received; held between frames.
- word_valid  out  1  one-cycle pulse when value updates.
- frame_err  out  1  sticky; set when a frame ends with 1..WIDTH-1 bits; cleared by the next complete word.

Behaviour:
- Reset values: value=0, word_valid=0, frame_err=0, miso=0, shift register=0, bit count=0, tx register=0, state=IDLE.
- Synchronizer flops reset to idle line levels: sclk 0, cs_n 1, mosi 0.
- Edge detection:
  - Each synchronized signal is compared with a one-cycle-delayed copy.
  - rise_sclk, fall_sclk, fall_cs and rise_cs are single-cycle strobes in clk.
- State machine:
  - IDLE: wait for fall_cs. On fall_cs: load tx register from value, drive miso with tx MSB, clear bit count, go to RECV.
  - RECV:
    - On rise_sclk: shift = {shift[WIDTH-2:0], mosi_sync}, count+1.
    - On fall_sclk: shift tx left by one, drive miso with the new tx MSB.
    - On the rise_sclk that brings count to WIDTH: value <= assembled word and word_valid=1, both visible the cycle after detection. Also clear frame_err and go to DONE.
    - On rise_cs with count in 1..WIDTH-1: set frame_err, leave value unchanged, go to IDLE.
    - On rise_cs with count 0: go to IDLE, no error.
  - DONE: ignore sclk edges; extra bits are discarded, not wrapped. On rise_cs, go to IDLE.
- Simultaneous rise_cs and rise_sclk in one cycle: rise_cs wins. The bit is not shifted in and the frame ends.
- End-to-end latency: pad edge to value/word_valid is SYNC_STAGES+2 clk cycles.
- word_valid is never asserted two cycles in a row. At most one pulse per frame.
- miso holds its last bit while cs_n is high. There is no tri-state; the top level gates miso if needed.
- Reset mid-frame: all state clears immediately. After reset releases, the block stays in IDLE until a new fall_cs. A cs_n already low at release does not start a frame.

Decomposition:
- Shared package spi_pkg: the WIDTH default, state encoding localparams (IDLE, RECV, DONE), and the synchronizer reset levels.
- One natural sub-module: spi_sync_edge, a SYNC_STAGES-deep synchronizer plus rise/fall strobe generator.
  - Parameterized by reset level.
  - Instantiated three times, for sclk, cs_n and mosi; the mosi instance uses only its synchronized output.

Test Plan:
- Basic capture:
  - Stimulus: cs_n low; clock in 0xA5C3 with sclk = clk/10; cs_n high.
  - Required: value=0xA5C3, exactly one word_valid pulse, SYNC_STAGES+2 cycles after the 16th sclk rise; frame_err=0.
- Readback:
  - Stimulus: after 0xA5C3 is held, send 0x1234.
  - Required: miso bits sampled on sclk rises read 0xA5C3; value becomes 0x1234.
- Short frame:
  - Stimulus: with value=0x1234, send 9 bits, then raise cs_n.
  - Required: frame_err=1, value stays 0x1234, no word_valid.
  - Follow-up: a full frame with 0x00FF then gives value=0x00FF and frame_err=0.
- Long frame:
  - Stimulus: send 20 bits where the first 16 are 0xBEEF.
  - Required: value=0xBEEF, one word_valid pulse, trailing 4 bits ignored, frame_err=0.
- Reset mid-frame:
  - Stimulus: pull rst low after 8 bits of 0xFFFF.
  - Required: value=0, frame_err=0, miso=0 immediately, with no clk edge needed. After release, cs_n is still low and more sclk pulses arrive; value does not change until a fresh cs_n fall starts a frame.
- Empty frame:
  - Stimulus: cs_n low, then high with no sclk edges.
  - Required: no word_valid, frame_err unchanged, value unchanged.
